ripple_count_sampler: RTL
=========================

// Module: ripple_count_sampler
// PURPOSE
//  Downstream consumer of the asynchronous (ripple) up/down counter. Brings the rippling count
//  bus into the clk domain with a 2-flop synchronizer, waits until it has stopped rippling,
//  then delivers one settled snapshot per request over a valid/ready handshake. Each snapshot
//  carries a wrap flag (terminal-count crossing since the previous snapshot) and a timeout
//  error flag (the value never settled).
// PARAMETERS
//  SIZE           4   count width; matches the upstream counter SIZE
//  STABLE_CYCLES  3   consecutive equal synchronized samples that count as settled; >=1
//  TIMEOUT        16  max WAIT cycles before a forced capture; >STABLE_CYCLES+2
// PORTS
//  clk        in   1     system clock
//  rst        in   1     asynchronous, active-low reset
//  cnt_in     in   SIZE  ripple counter q bus; asynchronous to clk
//  up         in   1     counter direction (1=up, 0=down); quasi-static, used unsynchronized
//  sample_req in   1     request one snapshot; level, sampled on each clk edge
//  cnt_out    out  SIZE  captured settled count
//  cnt_valid  out  1     cnt_out/cnt_wrap/cnt_err valid
//  out_ready  in   1     consumer accepts the snapshot
//  cnt_wrap   out  1     count crossed its terminal value since the previous snapshot
//  cnt_err    out  1     snapshot was forced by timeout, not settled
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): sync1, sync2, prev, last, cnt_out = 0; stable_cnt, tmo_cnt = 0;
//    cnt_valid, cnt_wrap, cnt_err, busy = 0; state = IDLE. Applies mid-operation: any WAIT
//    or HOLD is abandoned and the pending snapshot is lost.
//  - Synchronizer: sync1<=cnt_in; sync2<=sync1 (per bit, every edge).
//  - Settle filter (free-running, independent of state): prev<=sync2;
//    if sync2==prev then stable_cnt<=min(stable_cnt+1, STABLE_CYCLES) else stable_cnt<=0.
//    settled = (stable_cnt==STABLE_CYCLES).
//    stable_cnt width = $clog2(STABLE_CYCLES+1); tmo_cnt width = $clog2(TIMEOUT+1).
//  - FSM IDLE/WAIT/HOLD:
//    IDLE: sample_req=1 -> WAIT, tmo_cnt<=0.
//    WAIT: settled -> capture, HOLD. Else if tmo_cnt==TIMEOUT-1 -> forced capture, HOLD.
//          Else tmo_cnt<=tmo_cnt+1. settled wins when both happen in the same cycle.
//    capture: cnt_out<=sync2; cnt_err<=forced; cnt_wrap<=up ? (sync2<last) : (sync2>last);
//             last<=sync2; cnt_valid<=1.
//    HOLD: outputs held stable while out_ready=0. out_ready=1 -> cnt_valid<=0, and
//          sample_req=1 in that same cycle -> WAIT (tmo_cnt<=0), else -> IDLE.
//  - sample_req in WAIT, or in HOLD without out_ready, is ignored (not queued).
//  - Latency: with input already settled, an IDLE request seen at edge k gives cnt_valid=1
//    after edge k+1. After a cnt_in change, settle needs 2 sync edges + STABLE_CYCLES edges.
//  - Wrap: up=1 and new<last, or up=0 and new>last. Multiple wraps between snapshots look
//    like at most one (documented limitation). First snapshot after reset compares to 0.
//  - Only settled values reach cnt_out; a mid-ripple code can only appear with cnt_err=1.
// TESTING
//  1. Reset; cnt_in=4'h5 held; req 1 cycle after settle -> cnt_valid next cycle, cnt_out=5,
//     cnt_wrap=0, cnt_err=0; out_ready=1 -> cnt_valid=0, busy=0.
//  2. up=1: snapshot 4'hE, then cnt_in 4'hF->4'h0->4'h2; snapshot -> cnt_out=2, cnt_wrap=1.
//     up=0: snapshot 4'h1, then 4'h0->4'hF->4'hD; snapshot -> cnt_out=D, cnt_wrap=1.
//  3. cnt_in toggling 4'h7/4'h8 every 2 clk; req -> after 16 WAIT cycles cnt_valid=1,
//     cnt_err=1, cnt_out in {7,8}.
//  4. Hold out_ready=0 for 10 cycles with cnt_in changing -> cnt_out/flags constant; then
//     out_ready=1 with sample_req=1 -> next snapshot reflects the new value, no IDLE cycle.
//  5. Drop rst=0 in WAIT and in HOLD -> all outputs 0 immediately; after release, req ->
//     normal snapshot with cnt_wrap computed against last=0.

Source files
------------

// File: rtl/ripple_count_sampler.sv
// Ripple counter sampler: 2-flop sync, settle filter and one
// settled snapshot per request over a valid/ready handshake.
module ripple_count_sampler #(
  parameter int SIZE          = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int TIMEOUT       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] cnt_in,
  input  logic            up,
  input  logic            sample_req,
  output logic [SIZE-1:0] cnt_out,
  output logic            cnt_valid,
  input  logic            out_ready,
  output logic            cnt_wrap,
  output logic            cnt_err,
  output logic            busy
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t          state_q;
  logic [SIZE-1:0] sync1_q;
  logic [SIZE-1:0] sync2_q;
  logic [SIZE-1:0] prev_q;
  logic [SIZE-1:0] last_q;
  logic [SIZE-1:0] cnt_q;
  logic [SW-1:0]   stable_q;
  logic [SW-1:0]   stable_d;
  logic [TW-1:0]   tmo_q;
  logic            valid_q;
  logic            wrap_q;
  logic            err_q;
  logic            settled;
  logic            wrap_d;

  assign settled = (stable_q == STAB_MAX);

  // Direction is quasi-static, so it is used without synchronizing.
  assign wrap_d = up ? (sync2_q < last_q)
                     : (sync2_q > last_q);

  always_comb begin
    stable_d = '0;
    if (sync2_q != prev_q) begin
      stable_d = '0;
    end else if (settled) begin
      stable_d = STAB_MAX;
    end else begin
      stable_d = stable_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= cnt_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      stable_q <= stable_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sample_req) begin
            state_q <= WAIT;
            tmo_q   <= '0;
          end
        end
        WAIT: begin
          // A settled value wins over a simultaneous timeout.
          if (settled || (tmo_q == TMO_LAST)) begin
            cnt_q   <= sync2_q;
            err_q   <= !settled;
            wrap_q  <= wrap_d;
            last_q  <= sync2_q;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (sample_req) begin
              state_q <= WAIT;
              tmo_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt_out   = cnt_q;
  assign cnt_valid = valid_q;
  assign cnt_wrap  = wrap_q;
  assign cnt_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule
